normshift_iter: RTL and testbench
=================================

// Module: normshift_iter
// PURPOSE
//  Iterative normalization left-shifter that produces the normalized mantissa, exponent and shift count for post-processing.
//  Sits upstream of the FPU post-processing shift correction, in place of the one-cycle normalization shifter on area-reduced configs.
//  Shifts out leading zeros a few bits per cycle, clamped by a caller-supplied limit so subnormal results stop at the minimum exponent.
//  Valid/ready handshake on both sides; one operation in flight.
// PARAMETERS
//  WIDTH  64  mantissa/shifter width in bits (set to NORMSHIFTSZ on integration)
//  EW     13  exponent width in bits, two's complement (set to NE+2)
//  STEP   8   max left-shift per cycle; power of 2, 1 <= STEP <= WIDTH
//  SW     $clog2(WIDTH)+1  width of shift limit/count (derived, do not override)
// PORTS
//  clk        in   1      clock
//  reset      in   1      synchronous, active-high reset
//  Flush      in   1      synchronous abort of any operation in flight
//  InValid    in   1      input operand valid
//  InReady    out  1      block can accept an operand
//  InMant     in   WIDTH  unnormalized mantissa, MSB is the integer-bit position
//  InExp      in   EW     exponent corresponding to InMant as presented
//  ShiftLimit in   SW     max total left shift allowed (InExp - min normal exponent, clamped by caller)
//  OutValid   out  1      result valid
//  OutReady   in   1      consumer accepts result
//  Shifted    out  WIDTH  left-shifted mantissa
//  OutExp     out  EW     InExp - ShiftAmt, modulo 2^EW
//  ShiftAmt   out  SW     total left shift applied
//  Subnorm    out  1      limit reached with Shifted[WIDTH-1]==0 and mantissa nonzero
//  Zero       out  1      InMant was all zeros
// BEHAVIOUR
//  States IDLE, SHIFT, DONE. Reset -> IDLE; all registers 0; InReady=1, OutValid=0, all data outputs 0.
//  IDLE: InReady=1. InValid&InReady loads Mant<=InMant, Exp<=InExp, Rem<=ShiftLimit, Cnt<=0; -> SHIFT.
//  SHIFT: InReady=0, OutValid=0. Termination checked on registered values at start of cycle:
//   - Mant==0: Zero<=1, -> DONE (no shift, Cnt stays 0).
//   - Mant[WIDTH-1]==1: -> DONE.
//   - Rem==0: Subnorm<=1, -> DONE.
//   - else lz = leading zeros of Mant[WIDTH-1 -: STEP] (STEP if all zero); amt = min(lz, Rem);
//     Mant<=Mant<<amt (zero fill), Rem<=Rem-amt, Cnt<=Cnt+amt; stay in SHIFT.
//  DONE: OutValid=1, outputs stable while OutValid&~OutReady. OutExp = Exp - zero-extended Cnt, EW-bit wrap.
//   OutValid&OutReady -> IDLE; no new acceptance in the same cycle (InReady only in IDLE).
//  Latency: OutValid first rises 2+ceil(min(L,ShiftLimit)/STEP) cycles after acceptance, L = leading zeros of InMant;
//   zero mantissa or already-normalized input: 2 cycles.
//  ShiftLimit >= WIDTH behaves as unlimited; ShiftLimit==0 returns InMant unshifted, Subnorm=1 if MSB==0 and nonzero.
//  Zero and Subnorm are mutually exclusive; both 0 on normal result.
//  Flush in any state: -> IDLE next cycle, OutValid=0, result dropped; Flush wins over simultaneous InValid/OutReady.
//  reset mid-operation: same as Flush plus all data registers cleared.
//  Shifted/OutExp/ShiftAmt/Subnorm/Zero hold last values outside DONE; consumers qualify with OutValid only.
// TESTING (bench: WIDTH=16, EW=8, STEP=4)
//  InMant=16'h8000, InExp=8'd10, ShiftLimit=15 -> OutValid 2 cycles later; Shifted=16'h8000, OutExp=10, ShiftAmt=0, Subnorm=0.
//  InMant=16'h0003, InExp=8'd20, ShiftLimit=15 -> shifts 4,4,4,2; OutValid at cycle 6; Shifted=16'hC000, ShiftAmt=14, OutExp=6.
//  InMant=16'h0010, InExp=8'd2, ShiftLimit=5 -> shifts 4,1; Shifted=16'h0200, ShiftAmt=5, OutExp=8'hFD, Subnorm=1.
//  InMant=16'h0000, InExp=8'd7 -> OutValid at cycle 2; Zero=1, Shifted=0, ShiftAmt=0, OutExp=7.
//  Hold OutReady=0 for 5 cycles in DONE, then 1 -> outputs stable, one handshake, InReady returns next cycle.
//  Flush (and separately reset) asserted in SHIFT with InMant=16'h0001 -> IDLE next cycle, OutValid never rises, next op correct.

Source files
------------

// File: rtl/normshift_iter.sv
// Iterative normalization left-shifter: strips leading zeros up to STEP bits per cycle,
// stopping at a caller-supplied shift limit so subnormal results land on the minimum exponent.
module normshift_iter #(
   parameter int WIDTH = 64,
   parameter int EW    = 13,
   parameter int STEP  = 8,
   localparam int SW   = $clog2(WIDTH) + 1
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             Flush,
   input  logic             InValid,
   output logic             InReady,
   input  logic [WIDTH-1:0] InMant,
   input  logic [EW-1:0]    InExp,
   input  logic [SW-1:0]    ShiftLimit,
   output logic             OutValid,
   input  logic             OutReady,
   output logic [WIDTH-1:0] Shifted,
   output logic [EW-1:0]    OutExp,
   output logic [SW-1:0]    ShiftAmt,
   output logic             Subnorm,
   output logic             Zero
);

   typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_DONE} state_t;

   state_t           state_q, state_d;
   logic [WIDTH-1:0] mant_q, mant_d;
   logic [EW-1:0]    exp_q, exp_d;
   logic [SW-1:0]    rem_q, rem_d;
   logic [SW-1:0]    cnt_q, cnt_d;
   logic [WIDTH-1:0] shifted_q, shifted_d;
   logic [EW-1:0]    oexp_q, oexp_d;
   logic [SW-1:0]    amt_q, amt_d;
   logic             zero_q, zero_d;
   logic             subnorm_q, subnorm_d;

   logic [SW-1:0]    lz;
   logic [SW-1:0]    amt;
   logic             fin;

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q   <= S_IDLE;
         mant_q    <= '0;
         exp_q     <= '0;
         rem_q     <= '0;
         cnt_q     <= '0;
         shifted_q <= '0;
         oexp_q    <= '0;
         amt_q     <= '0;
         zero_q    <= 1'b0;
         subnorm_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         mant_q    <= mant_d;
         exp_q     <= exp_d;
         rem_q     <= rem_d;
         cnt_q     <= cnt_d;
         shifted_q <= shifted_d;
         oexp_q    <= oexp_d;
         amt_q     <= amt_d;
         zero_q    <= zero_d;
         subnorm_q <= subnorm_d;
      end
   end

   always_comb begin
      state_d   = state_q;
      mant_d    = mant_q;
      exp_d     = exp_q;
      rem_d     = rem_q;
      cnt_d     = cnt_q;
      shifted_d = shifted_q;
      oexp_d    = oexp_q;
      amt_d     = amt_q;
      zero_d    = zero_q;
      subnorm_d = subnorm_q;
      fin       = 1'b0;

      // Leading zeros within the top STEP-bit window; lowest set index wins.
      lz = SW'(STEP);
      for (int i = STEP - 1; i >= 0; i--) begin
         if (mant_q[WIDTH-1-i]) lz = SW'(i);
      end
      amt = (lz < rem_q) ? lz : rem_q;

      if (Flush) begin
         state_d = S_IDLE;
      end else begin
         case (state_q)
            S_IDLE: begin
               if (InValid) begin
                  mant_d  = InMant;
                  exp_d   = InExp;
                  rem_d   = ShiftLimit;
                  cnt_d   = '0;
                  state_d = S_SHIFT;
               end
            end
            S_SHIFT: begin
               if (mant_q == '0) begin
                  fin       = 1'b1;
                  zero_d    = 1'b1;
                  subnorm_d = 1'b0;
               end else if (mant_q[WIDTH-1]) begin
                  fin       = 1'b1;
                  zero_d    = 1'b0;
                  subnorm_d = 1'b0;
               end else if (rem_q == '0) begin
                  fin       = 1'b1;
                  zero_d    = 1'b0;
                  subnorm_d = 1'b1;
               end else begin
                  mant_d = mant_q << amt;
                  rem_d  = rem_q - amt;
                  cnt_d  = cnt_q + amt;
               end
               // Output registers only change on entry to DONE so they hold elsewhere.
               if (fin) begin
                  shifted_d = mant_q;
                  oexp_d    = exp_q - EW'(cnt_q);
                  amt_d     = cnt_q;
                  state_d   = S_DONE;
               end
            end
            S_DONE: begin
               if (OutReady) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
         endcase
      end
   end

   assign InReady  = (state_q == S_IDLE);
   assign OutValid = (state_q == S_DONE);
   assign Shifted  = shifted_q;
   assign OutExp   = oexp_q;
   assign ShiftAmt = amt_q;
   assign Subnorm  = subnorm_q;
   assign Zero     = zero_q;

endmodule

// File: tb/tb_normshift_iter.sv
// Randomized and directed bench for normshift_iter against an arithmetic reference model.
module tb_normshift_iter;

   localparam int W  = 16;
   localparam int E  = 8;
   localparam int ST = 4;
   localparam int SW = $clog2(W) + 1;

   logic          clk;
   logic          reset;
   logic          Flush;
   logic          InValid;
   logic          InReady;
   logic [W-1:0]  InMant;
   logic [E-1:0]  InExp;
   logic [SW-1:0] ShiftLimit;
   logic          OutValid;
   logic          OutReady;
   logic [W-1:0]  Shifted;
   logic [E-1:0]  OutExp;
   logic [SW-1:0] ShiftAmt;
   logic          Subnorm;
   logic          Zero;

   int n_chk  = 0;
   int n_pass = 0;

   normshift_iter #(.WIDTH(W), .EW(E), .STEP(ST)) dut (
      .clk        (clk),
      .reset      (reset),
      .Flush      (Flush),
      .InValid    (InValid),
      .InReady    (InReady),
      .InMant     (InMant),
      .InExp      (InExp),
      .ShiftLimit (ShiftLimit),
      .OutValid   (OutValid),
      .OutReady   (OutReady),
      .Shifted    (Shifted),
      .OutExp     (OutExp),
      .ShiftAmt   (ShiftAmt),
      .Subnorm    (Subnorm),
      .Zero       (Zero)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
      n_chk++;
      if (obs === exp_v) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", tag, obs, exp_v);
   endtask

   function automatic int lead_zeros(input logic [W-1:0] m);
      int n = 0;
      while (n < W && !m[W-1-n]) n++;
      return n;
   endfunction

   task automatic wait_in_ready();
      int k = 0;
      while (!InReady && k < 30) begin
         @(posedge clk); #1;
         k++;
      end
      chk("in_ready_wait", {31'd0, InReady}, 32'd1);
   endtask

   task automatic run_op(input logic [W-1:0] m, input logic [E-1:0] e,
                         input logic [SW-1:0] lim, input int hold);
      int            lz, eff, lat, cyc;
      logic [W-1:0]  x_sh;
      logic [E-1:0]  x_exp;
      logic          x_zero, x_sub;

      lz     = lead_zeros(m);
      x_zero = (m == '0);
      eff    = x_zero ? 0 : ((lz < int'(lim)) ? lz : int'(lim));
      x_sh   = m << eff;
      x_exp  = e - E'(eff);
      x_sub  = !x_zero && !x_sh[W-1];
      lat    = 2 + (eff + ST - 1) / ST;

      wait_in_ready();
      InMant     = m;
      InExp      = e;
      ShiftLimit = lim;
      InValid    = 1'b1;
      @(posedge clk); #1;
      InValid = 1'b0;
      cyc     = 1;
      while (!OutValid && cyc < 40) begin
         @(posedge clk); #1;
         cyc++;
      end
      chk("latency", cyc, lat);
      OutReady = 1'b0;
      for (int h = 0; h < hold; h++) begin
         @(posedge clk); #1;
         chk("hold_valid", {31'd0, OutValid}, 32'd1);
         chk("hold_shifted", {16'd0, Shifted}, {16'd0, x_sh});
      end
      chk("out_valid", {31'd0, OutValid}, 32'd1);
      chk("shifted", {16'd0, Shifted}, {16'd0, x_sh});
      chk("out_exp", {24'd0, OutExp}, {24'd0, x_exp});
      chk("shift_amt", {27'd0, ShiftAmt}, 32'(eff));
      chk("subnorm", {31'd0, Subnorm}, {31'd0, x_sub});
      chk("zero", {31'd0, Zero}, {31'd0, x_zero});
      OutReady = 1'b1;
      @(posedge clk); #1;
      OutReady = 1'b0;
      chk("ov_after_hs", {31'd0, OutValid}, 32'd0);
      chk("ir_after_hs", {31'd0, InReady}, 32'd1);
   endtask

   task automatic abort_test(input bit use_reset);
      bit seen;
      wait_in_ready();
      InMant     = 16'h0001;
      InExp      = 8'd40;
      ShiftLimit = 5'd15;
      InValid    = 1'b1;
      @(posedge clk); #1;
      InValid = 1'b0;
      @(posedge clk); #1;
      if (use_reset) reset = 1'b1;
      else Flush = 1'b1;
      OutReady = 1'b1;
      @(posedge clk); #1;
      reset    = 1'b0;
      Flush    = 1'b0;
      OutReady = 1'b0;
      chk(use_reset ? "rst_idle" : "flush_idle", {30'd0, OutValid, InReady}, 32'd1);
      if (use_reset) begin
         chk("rst_shifted", {16'd0, Shifted}, 32'd0);
         chk("rst_amt", {27'd0, ShiftAmt}, 32'd0);
         chk("rst_exp", {24'd0, OutExp}, 32'd0);
      end
      seen = 1'b0;
      repeat (20) begin
         @(posedge clk); #1;
         if (OutValid) seen = 1'b1;
      end
      chk(use_reset ? "rst_no_ov" : "flush_no_ov", {31'd0, seen}, 32'd0);
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [W-1:0] m;
      reset      = 1'b1;
      Flush      = 1'b0;
      InValid    = 1'b0;
      OutReady   = 1'b0;
      InMant     = '0;
      InExp      = '0;
      ShiftLimit = '0;
      repeat (3) @(posedge clk);
      #1 reset = 1'b0;

      chk("rst_in_ready", {31'd0, InReady}, 32'd1);
      chk("rst_out_valid", {31'd0, OutValid}, 32'd0);
      chk("rst_outs", {Shifted, OutExp, ShiftAmt, Subnorm, Zero}, 32'd0);

      run_op(16'h8000, 8'd10, 5'd15, 0);
      run_op(16'h0003, 8'd20, 5'd15, 0);
      run_op(16'h0010, 8'd2,  5'd5,  0);
      run_op(16'h0000, 8'd7,  5'd15, 0);
      run_op(16'h0003, 8'd20, 5'd15, 5);
      run_op(16'h0001, 8'd0,  5'd31, 1);
      run_op(16'h0040, 8'd5,  5'd0,  0);
      run_op(16'h8001, 8'd3,  5'd0,  0);
      run_op(16'h0300, 8'd9,  5'd16, 0);

      abort_test(1'b0);
      run_op(16'h0020, 8'd50, 5'd15, 0);
      abort_test(1'b1);
      run_op(16'h0005, 8'd1,  5'd20, 0);

      for (int t = 0; t < 60; t++) begin
         m = 16'($urandom);
         m = m >> $urandom_range(0, 16);
         run_op(m, 8'($urandom), 5'($urandom_range(0, 31)), int'($urandom_range(0, 2)));
      end

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
